// File: rtl/count_enable_gen.sv
// Button/mode conditioning and toggle-enable strobe for the 4-bit counter.
// Optional HOLD_REPEAT_EN adds hold-to-repeat strobes in manual mode.
module count_enable_gen #(
  parameter int DEB_CYCLES   = 16,
  parameter int DEB_W        = 5,
  parameter int PRESCALE     = 10,
  parameter int PS_W         = 4,
  parameter int REPEAT_DELAY = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic mode,
  output logic t,
  output logic btn_db,
  output logic run
);

  typedef enum logic [1:0] {
    S_MAN,
    S_AUTO_STOP,
    S_AUTO_RUN
  } state_t;

  state_t state;

  logic btn_m;
  logic btn_s;
  logic mode_m;
  logic mode_s;
  logic [DEB_W-1:0] deb_cnt;
  logic [PS_W-1:0] ps_cnt;
  logic press_r;
  logic db_rise;
  logic mode_chg;
  logic rep;

  assign db_rise = btn_s && !btn_db &&
                   (deb_cnt == DEB_W'(DEB_CYCLES - 1));

  assign mode_chg = (state == S_MAN) ? mode_s : !mode_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_m   <= 1'b0;
      btn_s   <= 1'b0;
      mode_m  <= 1'b0;
      mode_s  <= 1'b0;
      btn_db  <= 1'b0;
      deb_cnt <= '0;
      press_r <= 1'b0;
    end else begin
      btn_m   <= btn_raw;
      btn_s   <= btn_m;
      mode_m  <= mode;
      mode_s  <= mode_m;
      press_r <= db_rise;
      if (btn_s == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        btn_db  <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

`ifdef HOLD_REPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_DELAY + PRESCALE + 1);

  // Zero means idle; a press arms the counter at 1.
  logic [HOLD_W-1:0] hold_cnt;

  assign rep = btn_db &&
               (hold_cnt == HOLD_W'(REPEAT_DELAY) ||
                hold_cnt == HOLD_W'(REPEAT_DELAY + PRESCALE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (mode_chg || state != S_MAN || !btn_db) begin
      hold_cnt <= '0;
    end else if (press_r) begin
      hold_cnt <= HOLD_W'(1);
    end else if (hold_cnt == HOLD_W'(REPEAT_DELAY + PRESCALE)) begin
      hold_cnt <= HOLD_W'(REPEAT_DELAY + 1);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign rep = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_MAN;
      t      <= 1'b0;
      run    <= 1'b0;
      ps_cnt <= '0;
    end else if (mode_chg) begin
      state  <= (state == S_MAN) ? S_AUTO_STOP : S_MAN;
      t      <= 1'b0;
      run    <= 1'b0;
      ps_cnt <= '0;
    end else begin
      unique case (state)
        S_MAN: begin
          t      <= press_r | rep;
          ps_cnt <= '0;
        end
        S_AUTO_STOP: begin
          t      <= 1'b0;
          ps_cnt <= '0;
          if (press_r) begin
            state <= S_AUTO_RUN;
            run   <= 1'b1;
          end
        end
        S_AUTO_RUN: begin
          // A stop press wins over a coincident wrap.
          if (press_r) begin
            state  <= S_AUTO_STOP;
            run    <= 1'b0;
            ps_cnt <= '0;
            t      <= 1'b0;
          end else if (ps_cnt == PS_W'(PRESCALE - 1)) begin
            ps_cnt <= '0;
            t      <= 1'b1;
          end else begin
            ps_cnt <= ps_cnt + 1'b1;
            t      <= 1'b0;
          end
        end
        default: begin
          state  <= S_MAN;
          t      <= 1'b0;
          run    <= 1'b0;
          ps_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_enable_gen.sv
// Bench for count_enable_gen: vector table, directed sequences, random vs model.
// Expectations for hold-to-repeat follow HOLD_REPEAT_EN.
module tb_count_enable_gen;

  localparam int DEB = 4;
  localparam int PS  = 10;
  localparam int RD  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0;
  logic mode = 1'b0;
  logic t;
  logic btn_db;
  logic run;

  count_enable_gen #(
    .DEB_CYCLES(DEB),
    .DEB_W(5),
    .PRESCALE(PS),
    .PS_W(4),
    .REPEAT_DELAY(RD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .mode(mode),
    .t(t),
    .btn_db(btn_db),
    .run(run)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: event timing from cycle arithmetic
  logic m_s1, m_s, m_ms1, m_ms, m_db, m_press;
  logic m_man, m_run, m_t, rep_on;
  int m_diff, run_t0, rep_t0;

  task automatic model_reset();
    m_s1 = 0; m_s = 0; m_ms1 = 0; m_ms = 0;
    m_db = 0; m_press = 0; m_diff = 0;
    m_man = 1; m_run = 0; m_t = 0;
    rep_on = 0; run_t0 = 0; rep_t0 = 0;
  endtask

  task automatic model_step(input logic b, input logic md,
                            input logic r);
    logic n_db, n_press, n_t, n_man, n_run, rp;
    int n_diff;
    if (!r) begin
      model_reset();
      return;
    end
    n_db = m_db; n_press = 0; n_diff = 0;
    if (m_s != m_db) begin
      if (m_diff + 1 == DEB) begin
        n_db = m_s;
        n_press = m_s;
      end else begin
        n_diff = m_diff + 1;
      end
    end
    n_t = 0; n_man = m_man; n_run = m_run;
    if (m_ms == m_man) begin
      n_man = !m_man;
      n_run = 0;
      rep_on = 0;
    end else if (m_man) begin
      rp = 0;
`ifdef HOLD_REPEAT_EN
      rp = rep_on && m_db && (cyc - rep_t0 >= RD) &&
           ((cyc - rep_t0 - RD) % PS == 0);
`endif
      n_t = m_press | rp;
      if (m_press) begin
        rep_on = 1;
        rep_t0 = cyc;
      end else if (!m_db) begin
        rep_on = 0;
      end
    end else if (!m_run) begin
      if (m_press) begin
        n_run = 1;
        run_t0 = cyc;
      end
    end else begin
      if (m_press) n_run = 0;
      else if ((cyc - run_t0) % PS == 0) n_t = 1;
    end
    m_s = m_s1; m_s1 = b;
    m_ms = m_ms1; m_ms1 = md;
    m_db = n_db; m_diff = n_diff; m_press = n_press;
    m_t = n_t; m_man = n_man; m_run = n_run;
  endtask

  task automatic check(input string nm, input logic act,
                       input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %b expected %b",
               nm, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act,
                           input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic b, input logic md,
                      input logic r);
    @(negedge clk);
    btn_raw = b; mode = md; rst_n = r;
    @(posedge clk);
    cyc++;
    model_step(b, md, r);
    #1;
    check("t", t, m_t);
    check("btn_db", btn_db, m_db);
    check("run", run, m_run);
  endtask

  typedef struct {
    logic b, md, r;
    logic et, edb, erun;
  } vec_t;

  vec_t tbl[12];
  int E, pulses, first_p, second_p;

  initial begin
    model_reset();
    // Reset held with button and mode active, then clean press.
    for (int i = 0; i < 3; i++) tbl[i] = '{1, 1, 0, 0, 0, 0};
    for (int k = 0; k < 9; k++)
      tbl[k+3] = '{1, 0, 1, (k == 6), (k >= 5), 0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].b, tbl[i].md, tbl[i].r);
      check("tbl_t", t, tbl[i].et);
      check("tbl_db", btn_db, tbl[i].edb);
      check("tbl_run", run, tbl[i].erun);
    end

    // Reset into auto mode: stays stopped, no strobe.
    repeat (3) step(1, 1, 0);
    repeat (6) step(0, 1, 1);
    check("auto_idle_run", run, 1'b0);

    // Bounce shorter than debounce window.
    repeat (10) step(0, 0, 1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(((i / 2) % 2) == 0, 0, 1);
      if (t) pulses++;
    end
    check_int("bounce_pulses", pulses, 0);
    repeat (10) begin step(1, 0, 1); if (t) pulses++; end
    repeat (12) begin step(0, 0, 1); if (t) pulses++; end
    check_int("press_pulses", pulses, 1);

    // Auto run: 5 strobes, stop exactly at a wrap.
    repeat (5) step(0, 1, 1);
    E = -1; pulses = 0;
    repeat (8) begin
      step(1, 1, 1);
      if (E < 0 && m_run) E = cyc;
    end
    check_int("run_started", (E >= 0) ? 1 : 0, 1);
    if (E < 0) E = cyc;
    while (cyc < E + 52) begin
      step(0, 1, 1);
      if (t) pulses++;
    end
    check_int("auto_pulses", pulses, 5);
    while (cyc < E + 63) step(0, 1, 1);
    repeat (10) begin
      step(1, 1, 1);
      if (cyc == E + 70) begin
        check("wrap_stop_t", t, 1'b0);
        check("wrap_stop_run", run, 1'b0);
      end
    end
    pulses = 0;
    repeat (40) begin step(0, 1, 1); if (t) pulses++; end
    check_int("stopped_pulses", pulses, 0);

    // Mode switch mid-run.
    repeat (8) step(1, 1, 1);
    repeat (5) step(0, 1, 1);
    check("run_again", run, 1'b1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1);
      if (i == 2) check("mode_sw_run", run, 1'b0);
      if (i >= 2 && t) pulses++;
    end
    check_int("mode_sw_pulses", pulses, 0);
    repeat (8) begin step(1, 0, 1); if (t) pulses++; end
    repeat (10) begin step(0, 0, 1); if (t) pulses++; end
    check_int("man_after_sw", pulses, 1);

    // Long hold in manual mode.
    pulses = 0; first_p = 0; second_p = 0;
    repeat (80) begin
      step(1, 0, 1);
      if (t) begin
        pulses++;
        if (pulses == 1) first_p = cyc;
        if (pulses == 2) second_p = cyc;
      end
    end
    repeat (30) begin step(0, 0, 1); if (t) pulses++; end
`ifdef HOLD_REPEAT_EN
    check_int("hold_pulses", pulses, 6);
    check_int("hold_gap", second_p - first_p, RD);
`else
    check_int("hold_pulses", pulses, 1);
`endif

    // Random segments against the model.
    begin
      logic rb, rm;
      int len;
      rm = 0;
      for (int s = 0; s < 150; s++) begin
        rb = $urandom_range(0, 1);
        if ($urandom_range(0, 7) == 0) rm = !rm;
        len = $urandom_range(1, 25);
        if ($urandom_range(0, 39) == 0) step(rb, rm, 0);
        repeat (len) step(rb, rm, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
